// File: rtl/mem_pkg.sv
// Shared encodings, payload types and alignment helper for the memory-stage access unit.
package mem_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned REG_W           = 5;
    localparam int unsigned TIMEOUT_CYC_DEF = 16;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    // Registered bus payload, held stable while an access is outstanding.
    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [3:0]        be;
        logic [DATA_W-1:0] wdata;
    } mem_bus_t;

    // Per-access context needed to finish a load when the ack arrives.
    typedef struct packed {
        logic [1:0]       addr_lo;
        logic [1:0]       size;
        logic             zext;
        logic             is_load;
        logic [REG_W-1:0] rd;
    } mem_ctx_t;

    // Size 2'b11 falls into the word rule.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables/replicated data and load extract/extend.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] store_data,
    input  logic              is_store,
    input  logic              zext,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        be_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] load_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = rdata[{addr_lo, 3'b000} +: 8];
        half_v  = rdata[{addr_lo[1], 4'b0000} +: 16];
        be_c    = 4'b0000;
        wdata_c = '0;
        load_c  = '0;
        case (size)
            SZ_BYTE: begin
                be_c    = 4'(1) << addr_lo;
                wdata_c = {4{store_data[7:0]}};
                load_c  = zext ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{store_data[15:0]}};
                load_c  = zext ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = store_data;
                load_c  = rdata;
            end
        endcase
        // Loads drive no lanes on the bus.
        if (!is_store) begin
            be_c    = 4'b0000;
            wdata_c = '0;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: issues req/ack data-memory accesses, stalls while pending, registers WB results.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              reloj,
    input  logic              resetMEM_n,
    input  logic              enableMEM,
    input  logic [DATA_W-1:0] DIR_MEM,
    input  logic [DATA_W-1:0] DI_MEM,
    input  logic [REG_W-1:0]  rd_rt,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stall_mem,
    output logic [DATA_W-1:0] DO_MEM,
    output logic [REG_W-1:0]  rd_wb,
    output logic              wb_valid,
    output logic              addr_err,
    output logic              bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    mem_bus_t          bus_q, bus_d;
    mem_ctx_t          ctx_q, ctx_d;
    logic [DATA_W-1:0] do_q, do_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic              wbv_q, wbv_d;
    logic              aerr_q, aerr_d;
    logic              berr_q, berr_d;

    logic              in_access;
    logic [1:0]        al_size, al_lo;
    logic              al_zext;
    logic [3:0]        be_c;
    logic [DATA_W-1:0] wdata_c, load_c;

    // Lane logic sees live inputs when capturing, latched context while waiting for ack.
    assign in_access = (state_q == ST_ACCESS);
    assign al_size   = in_access ? ctx_q.size    : mem_size;
    assign al_lo     = in_access ? ctx_q.addr_lo : DIR_MEM[1:0];
    assign al_zext   = in_access ? ctx_q.zext    : mem_unsigned;

    mem_lane_align u_align (
        .size       (al_size),
        .addr_lo    (al_lo),
        .store_data (DI_MEM),
        .is_store   (MemWrite),
        .zext       (al_zext),
        .rdata      (bus_rdata),
        .be_c       (be_c),
        .wdata_c    (wdata_c),
        .load_c     (load_c)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        bus_d     = bus_q;
        ctx_d     = ctx_q;
        do_d      = do_q;
        rd_d      = rd_q;
        wbv_d     = 1'b0;
        aerr_d    = 1'b0;
        berr_d    = 1'b0;
        stall_mem = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enableMEM) begin
                    if (!(MemRead || MemWrite)) begin
                        do_d  = DIR_MEM;
                        rd_d  = rd_rt;
                        wbv_d = 1'b1;
                    end else if (misaligned(mem_size, DIR_MEM[1:0])) begin
                        aerr_d = 1'b1;
                    end else begin
                        stall_mem     = 1'b1;
                        state_d       = ST_ACCESS;
                        cnt_d         = '0;
                        req_d         = 1'b1;
                        bus_d.we      = MemWrite;
                        bus_d.addr    = {DIR_MEM[DATA_W-1:2], 2'b00};
                        bus_d.be      = be_c;
                        bus_d.wdata   = wdata_c;
                        ctx_d.addr_lo = DIR_MEM[1:0];
                        ctx_d.size    = mem_size;
                        ctx_d.zext    = mem_unsigned;
                        ctx_d.is_load = !MemWrite;
                        ctx_d.rd      = rd_rt;
                    end
                end
            end
            default: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (bus_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    bus_d   = '0;
                    if (ctx_q.is_load) begin
                        do_d  = load_c;
                        rd_d  = ctx_q.rd;
                        wbv_d = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    bus_d   = '0;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    stall_mem = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge reloj or negedge resetMEM_n) begin
        if (!resetMEM_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            bus_q   <= '0;
            ctx_q   <= '0;
            do_q    <= '0;
            rd_q    <= '0;
            wbv_q   <= 1'b0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            bus_q   <= bus_d;
            ctx_q   <= ctx_d;
            do_q    <= do_d;
            rd_q    <= rd_d;
            wbv_q   <= wbv_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
        end
    end

    assign bus_req   = req_q;
    assign bus_we    = bus_q.we;
    assign bus_addr  = bus_q.addr;
    assign bus_be    = bus_q.be;
    assign bus_wdata = bus_q.wdata;
    assign DO_MEM    = do_q;
    assign rd_wb     = rd_q;
    assign wb_valid  = wbv_q;
    assign addr_err  = aerr_q;
    assign bus_err   = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

    logic        reloj = 1'b0;
    logic        resetMEM_n;
    logic        enableMEM;
    logic [31:0] DIR_MEM;
    logic [31:0] DI_MEM;
    logic [4:0]  rd_rt;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall_mem;
    logic [31:0] DO_MEM;
    logic [4:0]  rd_wb;
    logic        wb_valid;
    logic        addr_err;
    logic        bus_err;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_unit #(.TIMEOUT_CYC(16)) dut (
        .reloj        (reloj),
        .resetMEM_n   (resetMEM_n),
        .enableMEM    (enableMEM),
        .DIR_MEM      (DIR_MEM),
        .DI_MEM       (DI_MEM),
        .rd_rt        (rd_rt),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .stall_mem    (stall_mem),
        .DO_MEM       (DO_MEM),
        .rd_wb        (rd_wb),
        .wb_valid     (wb_valid),
        .addr_err     (addr_err),
        .bus_err      (bus_err)
    );

    always #5 reloj = ~reloj;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an op before the edge, check stall, then let it be captured and clear the op.
    task automatic issue(input logic rd_op, input logic wr_op, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd_i, input logic exp_stall, input string tag);
        @(negedge reloj);
        enableMEM    = 1'b1;
        MemRead      = rd_op;
        MemWrite     = wr_op;
        mem_size     = sz;
        mem_unsigned = uns;
        DIR_MEM      = addr;
        DI_MEM       = data;
        rd_rt        = rd_i;
        #1 chk({tag, "_stall"}, 32'(stall_mem), 32'(exp_stall));
        @(posedge reloj);
        #1;
        enableMEM = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
    endtask

    // One ACCESS cycle: drive ack/rdata, check req and stall, then advance past the edge.
    task automatic acc_cycle(input logic ack, input logic [31:0] rdata, input logic exp_stall,
                             input string tag);
        @(negedge reloj);
        bus_ack   = ack;
        bus_rdata = rdata;
        #1;
        chk({tag, "_req"}, 32'(bus_req), 32'd1);
        chk({tag, "_stall"}, 32'(stall_mem), 32'(exp_stall));
        @(posedge reloj);
        #1;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        resetMEM_n = 1'b0; enableMEM = 1'b0; DIR_MEM = '0; DI_MEM = '0; rd_rt = '0;
        MemRead = 1'b0; MemWrite = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0;
        bus_ack = 1'b0; bus_rdata = '0;
        #12;
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_do", DO_MEM, 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        @(negedge reloj);
        resetMEM_n = 1'b1;

        // Pass-through
        issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_1234, 32'h0, 5'd7, 1'b0, "pt");
        chk("pt_do", DO_MEM, 32'h0000_1234);
        chk("pt_rd", 32'(rd_wb), 32'd7);
        chk("pt_wbv", 32'(wb_valid), 32'd1);
        @(posedge reloj); #1;
        chk("pt_wbv_pulse", 32'(wb_valid), 32'd0);

        // Ack with no request outstanding is ignored
        @(negedge reloj); bus_ack = 1'b1;
        @(posedge reloj); #1; bus_ack = 1'b0;
        chk("idle_ack_wbv", 32'(wb_valid), 32'd0);
        chk("idle_ack_req", 32'(bus_req), 32'd0);

        // Signed byte load at 0x103, ack on third ACCESS cycle
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd9, 1'b1, "lb");
        chk("lb_req", 32'(bus_req), 32'd1);
        chk("lb_addr", bus_addr, 32'h0000_0100);
        chk("lb_we", 32'(bus_we), 32'd0);
        chk("lb_be", 32'(bus_be), 32'd0);
        chk("lb_wbv_pend", 32'(wb_valid), 32'd0);
        acc_cycle(1'b0, 32'h0, 1'b1, "lb_c1");
        acc_cycle(1'b0, 32'h0, 1'b1, "lb_c2");
        acc_cycle(1'b1, 32'h8000_0000, 1'b0, "lb_c3");
        chk("lb_do", DO_MEM, 32'hFFFF_FF80);
        chk("lb_rd", 32'(rd_wb), 32'd9);
        chk("lb_wbv", 32'(wb_valid), 32'd1);
        chk("lb_req_drop", 32'(bus_req), 32'd0);
        @(posedge reloj); #1;
        chk("lb_wbv_pulse", 32'(wb_valid), 32'd0);

        // Half store at 0x202, ack in first ACCESS cycle
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 5'd3, 1'b1, "sh");
        chk("sh_we", 32'(bus_we), 32'd1);
        chk("sh_be", 32'(bus_be), 32'hC);
        chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
        chk("sh_addr", bus_addr, 32'h0000_0200);
        acc_cycle(1'b1, 32'h0, 1'b0, "sh_c1");
        chk("sh_wbv", 32'(wb_valid), 32'd0);
        chk("sh_do_hold", DO_MEM, 32'hFFFF_FF80);

        // Byte store at 0x301, both MemRead and MemWrite set -> store
        issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0000_0055, 5'd4, 1'b1, "sb");
        chk("sb_we", 32'(bus_we), 32'd1);
        chk("sb_be", 32'(bus_be), 32'h2);
        chk("sb_wdata", bus_wdata, 32'h5555_5555);
        acc_cycle(1'b1, 32'h0, 1'b0, "sb_c1");
        chk("sb_wbv", 32'(wb_valid), 32'd0);

        // Unsigned half load, upper half
        issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 5'd5, 1'b1, "lhu");
        chk("lhu_be", 32'(bus_be), 32'd0);
        acc_cycle(1'b1, 32'h8765_4321, 1'b0, "lhu_c1");
        chk("lhu_do", DO_MEM, 32'h0000_8765);
        chk("lhu_wbv", 32'(wb_valid), 32'd1);

        // Misaligned word
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 5'd6, 1'b0, "mis");
        chk("mis_aerr", 32'(addr_err), 32'd1);
        chk("mis_req", 32'(bus_req), 32'd0);
        chk("mis_wbv", 32'(wb_valid), 32'd0);
        @(posedge reloj); #1;
        chk("mis_aerr_pulse", 32'(addr_err), 32'd0);
        chk("mis_req2", 32'(bus_req), 32'd0);

        // Timeout: 16 cycles with no ack
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 5'd10, 1'b1, "to");
        for (int i = 1; i < 16; i++) acc_cycle(1'b0, 32'h0, 1'b1, "to_w");
        acc_cycle(1'b0, 32'h0, 1'b0, "to_c16");
        chk("to_req", 32'(bus_req), 32'd0);
        chk("to_berr", 32'(bus_err), 32'd1);
        chk("to_wbv", 32'(wb_valid), 32'd0);
        chk("to_stall", 32'(stall_mem), 32'd0);
        @(posedge reloj); #1;
        chk("to_berr_pulse", 32'(bus_err), 32'd0);

        // Ack exactly on cycle 16 completes normally
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0, 5'd11, 1'b1, "ak16");
        for (int i = 1; i < 16; i++) acc_cycle(1'b0, 32'h0, 1'b1, "ak16_w");
        acc_cycle(1'b1, 32'hDEAD_BEEF, 1'b0, "ak16_c16");
        chk("ak16_do", DO_MEM, 32'hDEAD_BEEF);
        chk("ak16_wbv", 32'(wb_valid), 32'd1);
        chk("ak16_berr", 32'(bus_err), 32'd0);
        chk("ak16_rd", 32'(rd_wb), 32'd11);

        // Reset mid-ACCESS
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0060, 32'h0, 5'd12, 1'b1, "ra");
        acc_cycle(1'b0, 32'h0, 1'b1, "ra_c1");
        @(negedge reloj);
        resetMEM_n = 1'b0;
        #1;
        chk("ra_req", 32'(bus_req), 32'd0);
        chk("ra_addr", bus_addr, 32'd0);
        chk("ra_do", DO_MEM, 32'd0);
        chk("ra_rd", 32'(rd_wb), 32'd0);
        chk("ra_stall", 32'(stall_mem), 32'd0);
        @(negedge reloj);
        resetMEM_n = 1'b1;
        @(posedge reloj); #1;
        chk("ra_wbv", 32'(wb_valid), 32'd0);

        // Word load after reset
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 5'd13, 1'b1, "lw");
        chk("lw_addr", bus_addr, 32'h0000_0080);
        acc_cycle(1'b0, 32'h0, 1'b1, "lw_c1");
        acc_cycle(1'b1, 32'h1122_3344, 1'b0, "lw_c2");
        chk("lw_do", DO_MEM, 32'h1122_3344);
        chk("lw_rd", 32'(rd_wb), 32'd13);
        chk("lw_wbv", 32'(wb_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller sitting directly downstream of the EX/MEM pipeline register. Consumes the registered ALU address, store data and destination register, performs byte/half/word loads and stores over a req/ack data-memory bus, stalls the pipeline while an access is outstanding, and presents registered results to the MEM/WB stage. Handles lane alignment, sign/zero extension, misalignment detection and bus timeout.

## Interface
- TIMEOUT_CYC, 16, max cycles in ACCESS awaiting bus_ack before abort (≥2)
- reloj  in  1  system clock, rising edge
- resetMEM_n  in  1  asynchronous, active-low reset
- enableMEM  in  1  EX/MEM contents valid this cycle
- DIR_MEM  in  32  byte address (ALU result)
- DI_MEM  in  32  store data (rt value)
- rd_rt  in  5  destination register
- MemRead / MemWrite  in  1 each  load / store request (both set → treated as store)
- mem_size  in  2  00 byte, 01 half, 10 word (11 → treated as word)
- mem_unsigned  in  1  zero-extend loads when 1
- bus_req  out  1  access request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  32  word-aligned address ({DIR_MEM[31:2],2'b00})
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  single-cycle completion
- bus_rdata  in  32  read word, valid with bus_ack
- stall_mem  out  1  freeze upstream stages (combinational)
- DO_MEM  out  32  load result or passed-through ALU value
- rd_wb  out  5  destination register to WB
- wb_valid  out  1  DO_MEM/rd_wb valid, one-cycle pulse per op
- addr_err / bus_err  out  1 each  one-cycle error pulses

## Operation
- States: IDLE, ACCESS.
- IDLE, enableMEM=0: nothing; wb_valid=0 next cycle.
- IDLE, enableMEM=1, no MemRead/MemWrite: next cycle DO_MEM=DIR_MEM, rd_wb=rd_rt, wb_valid=1; no stall.
- IDLE, memory op, misaligned (half with addr[0]=1, word with addr[1:0]≠0): next cycle addr_err=1, wb_valid=0, no bus activity, no stall.
- IDLE, memory op, aligned: latch addr/data/size/rd_rt, stall_mem=1 this cycle, → ACCESS.
- ACCESS: bus_req=1, bus_addr/bus_we/bus_be/bus_wdata stable from latched values. stall_mem = !bus_ack. On bus_ack → IDLE; next cycle wb_valid=1 for loads (DO_MEM = extracted data), wb_valid=0 for stores.
- Timeout: counter reset on ACCESS entry, increments each ACCESS cycle without ack; on reaching TIMEOUT_CYC with no ack → drop bus_req, → IDLE, next cycle bus_err=1, wb_valid=0, stall released in that cycle.
- Store lanes: byte → wdata {4{d[7:0]}}, be = 1<<addr[1:0]; half → {2{d[15:0]}}, be = addr[1]?1100:0011; word → d, 1111. bus_be=0 and bus_wdata=0 on loads.
- Load extract: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]; sign-extend unless mem_unsigned.
- Inputs ignored while in ACCESS (upstream is stalled).

## Timing
- Reset (resetMEM_n=0, async): state IDLE, all outputs 0 (bus_req, bus_we, bus_addr, bus_be, bus_wdata, DO_MEM, rd_wb, wb_valid, addr_err, bus_err), counter 0. Reset mid-ACCESS drops bus_req immediately; the access is abandoned, no wb_valid.
- Non-memory op latency: 1 cycle. Aligned access: bus_req first asserted cycle N+1 after capture at N; ack at cycle M → wb_valid at M+1.
- bus_ack in the first ACCESS cycle is legal (2-cycle total latency). bus_ack while bus_req=0 is ignored.
- Ack and timeout in the same cycle: ack wins.
- Back-to-back: a new op may be captured in the cycle after ack (IDLE).

## Structure
- Shared package mem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, state encoding, default TIMEOUT_CYC.
- Sub-module mem_lane_align (combinational): generates bus_be/bus_wdata from size+addr+data and extracts/extends load data; FSM, counter and output registers remain in mem_access_unit.

## Test plan
- Pass-through: enableMEM=1, no mem op, DIR_MEM=0x0000_1234, rd_rt=7 → next cycle DO_MEM=0x1234, rd_wb=7, wb_valid=1, stall_mem=0.
- Signed byte load: addr 0x103, size byte, rdata 0x8000_0000, ack after 3 cycles → bus_addr 0x100, DO_MEM=0xFFFF_FF80, wb_valid one cycle after ack, stall_mem high until ack cycle.
- Half store: addr 0x202, DI_MEM 0x1234_ABCD → bus_we=1, bus_be=1100, bus_wdata=0xABCD_ABCD; wb_valid stays 0.
- Misaligned word at 0x006 → addr_err pulse next cycle, bus_req never asserted, no stall.
- No ack for TIMEOUT_CYC=16 cycles → bus_req drops, bus_err pulse, stall released, wb_valid=0; ack arriving exactly on cycle 16 completes normally instead.
- resetMEM_n pulsed low mid-ACCESS → all outputs 0 asynchronously, state IDLE; subsequent word load completes normally.
